// File: rtl/one_hot_demux_ff.sv
// Request-side one-hot demux: latches one upstream request into the selected
// target slice, holds its strobe until that target acks or the watchdog fires.
module one_hot_demux_ff #(
    parameter int WIDTH   = 32,
    parameter int CNT     = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_vld,
    input  logic [CNT-1:0]       req_sel,
    input  logic [WIDTH-1:0]     req_data,
    output logic                 req_rdy,
    output logic [WIDTH*CNT-1:0] dout,
    output logic [CNT-1:0]       dout_vld,
    input  logic [CNT-1:0]       ack,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state_dbg
);

    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam int IW     = (CNT > 1) ? $clog2(CNT) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  wait_cnt;
    logic [IW-1:0]  tgt_idx;

    logic           sel_one_hot;
    logic [IW-1:0]  sel_idx;
    logic           ack_hit;
    logic           timeout_hit;

    // Handshake: a request transfers on a rising edge where req_vld && req_rdy;
    // req_rdy is high exactly while the FSM sits in IDLE.
    assign req_rdy   = (state == IDLE);
    assign state_dbg = state;

    assign sel_one_hot = (req_sel != '0) && ((req_sel & (req_sel - CNT'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < CNT; i++) begin
            if (req_sel[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    // Only the latched target's ack matters; strays on other bits are dropped.
    always_comb begin
        ack_hit = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            if (IW'(i) == tgt_idx) begin
                ack_hit = ack[i];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dout     <= '0;
            dout_vld <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            wait_cnt <= '0;
            tgt_idx  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_vld) begin
                        if (sel_one_hot) begin
                            for (int i = 0; i < CNT; i++) begin
                                if (IW'(i) == sel_idx) begin
                                    dout[WIDTH*i +: WIDTH] <= req_data;
                                end
                            end
                            dout_vld <= req_sel;
                            tgt_idx  <= sel_idx;
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (ack_hit || timeout_hit) begin
                        for (int i = 0; i < CNT; i++) begin
                            if (IW'(i) == tgt_idx) begin
                                dout[WIDTH*i +: WIDTH] <= '0;
                            end
                        end
                        dout_vld <= '0;
                        done     <= 1'b1;
                        err      <= !ack_hit;
                        state    <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        // Saturate so a disabled watchdog never wraps.
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_hot_demux_ff.sv
// Bench for one_hot_demux_ff: directed plan items plus randomized requests,
// completion checked by a scoreboard monitor against a latency/err model.
module tb_one_hot_demux_ff;

    localparam int W   = 32;
    localparam int N   = 5;
    localparam int TO  = 4;
    localparam int EW  = 33;

    logic             clk;
    logic             rst_n;
    logic             req_vld;
    logic [N-1:0]     req_sel;
    logic [W-1:0]     req_data;
    logic             req_rdy;
    logic [W*N-1:0]   dout;
    logic [N-1:0]     dout_vld;
    logic [N-1:0]     ack;
    logic             done;
    logic             err;
    logic [1:0]       state_dbg;

    int tests;
    int fails;
    int cyc;

    // {expected err, cycle number in which done must appear}
    logic [EW-1:0] exp_q[$];

    one_hot_demux_ff #(.WIDTH(W), .CNT(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_sel(req_sel),
        .req_data(req_data), .req_rdy(req_rdy), .dout(dout),
        .dout_vld(dout_vld), .ack(ack), .done(done), .err(err),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W*N-1:0] act, input logic [W*N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse consumes one expected completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e[31:0]);
                    check("done_err", err, e[32]);
                end
            end else if (err) begin
                check("err_without_done", err, 0);
            end
        end
    end

    task automatic wait_rdy();
        int k;
        k = 0;
        while (!req_rdy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rdy_wait", req_rdy, 1);
    endtask

    // ack_cyc: cycle (counted from accept) in which the target acks; > TO means never.
    task automatic send(input logic [N-1:0] sel, input logic [W-1:0] data,
                        input int ack_cyc, input bit foreign);
        bit            legal;
        int            idx;
        int            end_n;
        logic          exp_err;
        int            c0;
        logic [W*N-1:0] exp_dout;
        legal = ($countones(sel) == 1);
        idx = 0;
        for (int i = 0; i < N; i++) if (sel[i]) idx = i;
        wait_rdy();
        req_vld  = 1'b1;
        req_sel  = sel;
        req_data = data;
        c0 = cyc;
        if (!legal) begin
            end_n = 1; exp_err = 1'b1;
        end else if (ack_cyc <= TO) begin
            end_n = ack_cyc + 1; exp_err = 1'b0;
        end else begin
            end_n = TO + 1; exp_err = 1'b1;
        end
        exp_q.push_back({exp_err, 32'(c0 + end_n)});
        exp_dout = '0;
        exp_dout[W*idx +: W] = data;
        for (int n = 1; n <= end_n; n++) begin
            @(negedge clk);
            req_vld  = 1'b0;
            req_sel  = N'($urandom);
            req_data = $urandom;
            ack = foreign ? N'($urandom) : '0;
            if (legal) ack[idx] = (n == ack_cyc);
            if (legal && n < end_n) begin
                check("strobe_held", dout_vld, sel);
                check("dout_held", dout, exp_dout);
            end else begin
                check("strobe_clear", dout_vld, 0);
                check("dout_clear", dout, 0);
            end
            check("rdy_busy", req_rdy, 0);
        end
        @(negedge clk);
        ack = '0;
        check("rdy_back", req_rdy, 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_vld = 1'b0;
        req_sel = '0;
        req_data = '0;
        ack = '0;
        repeat (3) @(negedge clk);
        check("rst_vld", dout_vld, 0);
        check("rst_dout", dout, 0);
        check("rst_rdy", req_rdy, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_quiet", {req_rdy, done, err, dout_vld, dout}, {1'b1, 2'b00, {N{1'b0}}, {W*N{1'b0}}});
        end

        send(5'b00100, 32'hDEADBEEF, 3, 1'b0);
        send(5'b00000, 32'h12345678, 1, 1'b0);
        send(5'b01010, 32'h87654321, 1, 1'b0);
        send(5'b00001, 32'hA5A5A5A5, 99, 1'b1);
        send(5'b00001, 32'h5A5A5A5A, 4, 1'b1);
        send(5'b10000, 32'hCAFEF00D, 1, 1'b1);

        // Reset in cycle 2 of a WAIT: strobe and data drop at once, no done.
        wait_rdy();
        req_vld = 1'b1; req_sel = 5'b00010; req_data = 32'h0BADF00D;
        @(negedge clk);
        req_vld = 1'b0;
        check("pre_rst_strobe", dout_vld, 5'b00010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_vld", dout_vld, 0);
        check("async_rst_dout", dout, 0);
        @(negedge clk);
        check("rst_no_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        send(5'b00010, 32'h600DCAFE, 2, 1'b0);

        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] s;
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                s = N'($urandom);
                if ($countones(s) == 1) s = '0;
            end else begin
                s = N'(1) << $urandom_range(0, N - 1);
            end
            send(s, $urandom, $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
